led_pwm_dimmer: RTL and testbench

Parametrised multi-channel LED brightness controller: a shared free-running PWM counter drives CHANNELS active-low LED outputs. Each channel has its own mode (off, steady, blink, breathe) and brightness level. A one-cycle write port loads the mode and level for one channel. The block replaces fixed bit-OR dimming of the board RGB LED and sits between the top-level control logic and the LED pins.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_pwm_dimmer_if.sv | 26 ++
 rtl/led_pwm_chan.sv | 83 ++++++++
 rtl/led_pwm_dimmer.sv | 60 ++++++
 tb/tb_led_pwm_dimmer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED PWM dimmer: channel modes, breathe direction, address width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_STEADY  = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Channel address width; a single channel still gets a 1-bit address.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_dimmer_if.sv
// Write port and LED outputs of the dimmer, bundled for the control logic.
// Latency: n/a (wiring only).
// Backpressure: none; every write strobe is accepted in its cycle.
interface led_pwm_dimmer_if #(
    parameter int CHANNELS = 3,
    parameter int PWM_BITS = 8
) ();
    localparam int AW = led_pkg::addr_width(CHANNELS);

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [1:0]          wr_mode;
    logic [PWM_BITS-1:0] wr_level;
    logic                tick;
    logic [CHANNELS-1:0] led_n;

    modport master (
        output wr_en, wr_addr, wr_mode, wr_level,
        input  tick, led_n
    );

    modport slave (
        input  wr_en, wr_addr, wr_mode, wr_level,
        output tick, led_n
    );
endinterface

// File: rtl/led_pwm_chan.sv
// One LED channel: mode/level/ramp/dir state, duty select and registered active-low PWM output.
// Latency: write -> duty next cycle -> led_n one cycle later; led_n is a flop off pwm_cnt and duty.
// Backpressure: none; a write always wins over a coincident tick for this channel.
module led_pwm_chan
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_evt,
    input  logic                wr_sel,
    input  logic [1:0]          wr_mode,
    input  logic [PWM_BITS-1:0] wr_level,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_n
);

    led_mode_e           mode_q, mode_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] ramp_q, ramp_d;
    logic                dir_q, dir_d;
    logic [PWM_BITS-1:0] duty;

    // Next channel state: a write reloads everything, otherwise a tick advances the ramp.
    always_comb begin
        mode_d  = mode_q;
        level_d = level_q;
        ramp_d  = ramp_q;
        dir_d   = dir_q;
        if (wr_sel) begin
            mode_d  = led_mode_e'(wr_mode);
            level_d = wr_level;
            ramp_d  = '0;
            dir_d   = DIR_UP;
        end else if (tick_evt) begin
            case (mode_q)
                LED_BLINK: ramp_d = ramp_q + PWM_BITS'(1);
                LED_BREATHE: begin
                    // Turning points hold the ramp for one tick while dir flips.
                    if (dir_q == DIR_UP) begin
                        if (ramp_q < level_q) ramp_d = ramp_q + PWM_BITS'(1);
                        else                  dir_d  = DIR_DOWN;
                    end else begin
                        if (ramp_q != '0) ramp_d = ramp_q - PWM_BITS'(1);
                        else              dir_d  = DIR_UP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Effective duty cycle for the current mode.
    always_comb begin
        duty = '0;
        case (mode_q)
            LED_OFF:     duty = '0;
            LED_STEADY:  duty = level_q;
            LED_BLINK:   duty = ramp_q[PWM_BITS-1] ? '0 : level_q;
            LED_BREATHE: duty = ramp_q;
            default:     duty = '0;
        endcase
    end

    // Channel state and registered comparator output (lit while pwm_cnt < duty).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= LED_OFF;
            level_q <= '0;
            ramp_q  <= '0;
            dir_q   <= DIR_UP;
            led_n   <= 1'b1;
        end else begin
            mode_q  <= mode_d;
            level_q <= level_d;
            ramp_q  <= ramp_d;
            dir_q   <= dir_d;
            led_n   <= !(pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/led_pwm_dimmer.sv
// Multi-channel LED dimmer: shared PWM counter and prescaler, write decode, one led_pwm_chan per LED.
// Latency: led_n lags pwm_cnt/duty by one cycle; a write shows on led_n within two cycles.
// Backpressure: none; writes to addresses >= CHANNELS are dropped silently.
module led_pwm_dimmer
    import led_pkg::*;
#(
    parameter int CHANNELS      = 3,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16
) (
    input  logic               clk,
    input  logic               rst,
    led_pwm_dimmer_if.slave    bus
);

    localparam int AW = addr_width(CHANNELS);

    logic [PWM_BITS-1:0]      pwm_cnt;
    logic [PRESCALE_BITS-1:0] prescaler;
    logic                     tick_evt;
    logic                     tick_q;

    // Ramps advance on the edge that leaves the all-ones prescaler value.
    assign tick_evt = &prescaler;
    assign bus.tick = tick_q;

    // Free-running PWM counter, prescaler and the registered tick pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt   <= '0;
            prescaler <= '0;
            tick_q    <= 1'b0;
        end else begin
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            prescaler <= prescaler + PRESCALE_BITS'(1);
            tick_q    <= tick_evt;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic wr_sel;

        // Out-of-range addresses never equal a channel index, so they select nothing.
        assign wr_sel = bus.wr_en && (bus.wr_addr == AW'(i));

        led_pwm_chan #(
            .PWM_BITS (PWM_BITS)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .tick_evt (tick_evt),
            .wr_sel   (wr_sel),
            .wr_mode  (bus.wr_mode),
            .wr_level (bus.wr_level),
            .pwm_cnt  (pwm_cnt),
            .led_n    (bus.led_n[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Randomised bench for led_pwm_dimmer against a tick-count reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_pwm_dimmer;

    localparam int CH = 3;
    localparam int PB = 4;
    localparam int PS = 2;
    localparam int PWM_PERIOD = 1 << PB;
    localparam int TICK_PERIOD = 1 << PS;

    logic clk;
    logic rst;

    int n_chk;
    int n_err;

    led_pwm_dimmer_if #(.CHANNELS(CH), .PWM_BITS(PB)) bus ();

    led_pwm_dimmer #(
        .CHANNELS      (CH),
        .PWM_BITS      (PB),
        .PRESCALE_BITS (PS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: per channel the mode, level and ticks seen since the last write;
    // k is the number of clock edges since reset.
    int m_mode [CH];
    int m_lvl  [CH];
    int m_t    [CH];
    int k;
    logic [CH-1:0] exp_led;
    logic          exp_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // Duty from closed-form waveforms: blink is on for the first half of each 16-tick
    // cycle, breathe is a triangle with both end points held for one extra tick.
    function automatic int duty(input int c);
        int p;
        int lvl;
        lvl = m_lvl[c];
        case (m_mode[c])
            1: return lvl;
            2: return ((m_t[c] % PWM_PERIOD) < (PWM_PERIOD / 2)) ? lvl : 0;
            3: begin
                p = m_t[c] % (2 * (lvl + 1));
                return (p <= lvl) ? p : (2 * lvl + 1 - p);
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0;
            m_lvl[c]  = 0;
            m_t[c]    = 0;
        end
        k        = 0;
        exp_led  = '1;
        exp_tick = 1'b0;
    endtask

    task automatic model_edge(input logic we, input int addr, input int mode, input int lvl);
        bit tick_now;
        for (int c = 0; c < CH; c++)
            exp_led[c] = ((k % PWM_PERIOD) < duty(c)) ? 1'b0 : 1'b1;
        tick_now = ((k % TICK_PERIOD) == TICK_PERIOD - 1);
        for (int c = 0; c < CH; c++) begin
            if (we && addr == c) begin
                m_mode[c] = mode;
                m_lvl[c]  = lvl;
                m_t[c]    = 0;
            end else if (tick_now) begin
                m_t[c]++;
            end
        end
        k++;
        exp_tick = ((k % TICK_PERIOD) == 0);
    endtask

    task automatic step(input logic we, input logic [1:0] addr, input logic [1:0] mode,
                        input logic [PB-1:0] lvl);
        bus.wr_en    = we;
        bus.wr_addr  = addr;
        bus.wr_mode  = mode;
        bus.wr_level = lvl;
        @(posedge clk);
        model_edge(we, int'(addr), int'(mode), int'(lvl));
        #1;
        bus.wr_en = 1'b0;
        chk("led_n", 32'(bus.led_n), 32'(exp_led));
        chk("tick", 32'(bus.tick), 32'(exp_tick));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'd0, 2'd0, '0);
    endtask

    initial begin
        int lit;
        n_chk = 0;
        n_err = 0;
        rst          = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_mode  = '0;
        bus.wr_level = '0;
        model_reset();

        #20;
        chk("reset_led_n", 32'(bus.led_n), 32'd7);
        chk("reset_tick", 32'(bus.tick), 32'd0);
        #2;
        rst = 1'b1;

        // Idle after reset: everything dark, tick every 4 cycles.
        idle(200);

        // Steady channel 1 at level 5: lit exactly 5 of every 16 cycles.
        step(1'b1, 2'd1, 2'd1, 4'd5);
        idle(2);
        lit = 0;
        for (int i = 0; i < PWM_PERIOD; i++) begin
            step(1'b0, 2'd0, 2'd0, '0);
            if (bus.led_n[1] == 1'b0) lit++;
        end
        chk("steady_lit_per_window", 32'(lit), 32'd5);

        // Breathe channel 0 at level 3, then blink channel 2 at full level.
        step(1'b1, 2'd0, 2'd3, 4'd3);
        idle(200);
        step(1'b1, 2'd2, 2'd2, 4'd15);
        idle(160);

        // Breathe at level 0 stays dark.
        step(1'b1, 2'd1, 2'd3, 4'd0);
        idle(40);

        // Write landing on the tick edge: ramp restarts at 0 with no increment.
        while ((k % TICK_PERIOD) != TICK_PERIOD - 1) idle(1);
        step(1'b1, 2'd0, 2'd3, 4'd3);
        idle(40);

        // Out-of-range address changes nothing.
        step(1'b1, 2'd3, 2'd1, 4'd15);
        idle(40);

        // Random writes with gaps long enough for ramps to evolve.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0)
                step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     PB'($urandom_range(0, 15)));
            else
                idle(1);
        end

        // Asynchronous reset mid-breathe while tick is high.
        step(1'b1, 2'd0, 2'd3, 4'd15);
        idle(40);
        while ((k % TICK_PERIOD) != 0) idle(1);
        chk("pre_reset_tick", 32'(bus.tick), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_led_n", 32'(bus.led_n), 32'd7);
        chk("async_reset_tick", 32'(bus.tick), 32'd0);
        #2;
        rst = 1'b1;
        model_reset();
        idle(100);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
